// File: rtl/dunc_core.sv
// dunc_core: minimal accumulator CPU with a four-state instruction cycle.
//
// Each instruction passes T0 (fetch), T1 (decode), T2 (operand access) and
// T3 (execute / PC update). Memory is reached through a single
// request/acknowledge port; wait states are unbounded.
//
// Ports
//   CLK        clock, all state changes on its rising edge
//   RESET      synchronous active-high reset
//   MEM_REQ    memory access request
//   MEM_WE     1 = write, 0 = read (valid while MEM_REQ=1)
//   MEM_ADDR   access address
//   MEM_WDATA  write data (accumulator)
//   MEM_RDATA  read data, taken when MEM_REQ and MEM_ACK are both high
//   MEM_ACK    access complete
//   PC_OUT     program counter
//   AC_OUT     accumulator
//   IR_OUT     opcode of the current instruction
//   T_OUT      timing state (0..3)
//   FETCH      high in T0/T1
//   EXECUTE    high in T2/T3
//   CARRY      carry flag
//   HALTED     core stopped by HLT; only RESET restarts it
//
// Legal configurations need DATA_W >= ADDR_W + 4.
module dunc_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [DATA_W-1:0] AC_OUT,
  output logic [3:0]        IR_OUT,
  output logic [1:0]        T_OUT,
  output logic              FETCH,
  output logic              EXECUTE,
  output logic              CARRY,
  output logic              HALTED
);

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_STA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_JN  = 4'd8;

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] AC_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstate_e;

  // Opcodes that read their operand in T2.
  function automatic logic is_read_op(input logic [3:0] op);
    is_read_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  // Opcodes that touch memory in T2 (reads plus STA).
  function automatic logic is_mem_op(input logic [3:0] op);
    is_mem_op = is_read_op(op) || (op == OP_STA);
  endfunction

  tstate_e             t_q, t_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ac_q, ac_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                carry_q, carry_d;
  logic                halted_q, halted_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [3:0]          op_s;
  logic [3:0]          op_next_s;
  logic [ADDR_W-1:0]   opnd_s;
  logic [ADDR_W-1:0]   opnd_next_s;
  logic [DATA_W:0]     sum_s;
  logic                ack_s;
  logic                unused_ir_s;

  assign op_s        = ir_q[DATA_W-1 -: 4];
  assign opnd_s      = ir_q[ADDR_W-1:0];
  assign op_next_s   = ir_d[DATA_W-1 -: 4];
  assign opnd_next_s = ir_d[ADDR_W-1:0];
  assign sum_s       = {1'b0, ac_q} + {1'b0, mdr_q};
  // An acknowledge only counts while this core is actually requesting.
  assign ack_s       = req_q & MEM_ACK;
  // Instruction bits between the operand and the opcode are ignored.
  assign unused_ir_s = ^ir_q;

  // Instruction sequencing, datapath and PC update.
  always_comb begin
    t_d      = t_q;
    pc_d     = pc_q;
    ac_d     = ac_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    if (halted_q) begin
      t_d = t_q;
    end else begin
      case (t_q)
        T0: begin
          if (ack_s) begin
            ir_d = MEM_RDATA;
            t_d  = T1;
          end else begin
            t_d = T0;
          end
        end
        T1: t_d = T2;
        T2: begin
          if (is_mem_op(op_s)) begin
            if (ack_s) begin
              if (is_read_op(op_s)) begin
                mdr_d = MEM_RDATA;
              end else begin
                mdr_d = mdr_q;
              end
              t_d = T3;
            end else begin
              t_d = T2;
            end
          end else begin
            t_d = T3;
          end
        end
        T3: begin
          t_d  = T0;
          pc_d = pc_q + PC_ONE;
          case (op_s)
            OP_HLT: halted_d = 1'b1;
            OP_LDA: ac_d = mdr_q;
            OP_ADD: {carry_d, ac_d} = sum_s;
            OP_SUB: begin
              ac_d    = ac_q - mdr_q;
              carry_d = (ac_q >= mdr_q);
            end
            OP_AND: ac_d = ac_q & mdr_q;
            OP_JMP: pc_d = opnd_s;
            OP_JZ: begin
              if (ac_q == AC_ZERO) begin
                pc_d = opnd_s;
              end else begin
                pc_d = pc_q + PC_ONE;
              end
            end
            OP_JN: begin
              if (ac_q[DATA_W-1]) begin
                pc_d = opnd_s;
              end else begin
                pc_d = pc_q + PC_ONE;
              end
            end
            default: pc_d = pc_q + PC_ONE;
          endcase
        end
        default: t_d = T0;
      endcase
    end
  end

  // Bus outputs are registered from the next state so they stay frozen
  // for the whole wait period and drop the cycle after the acknowledge.
  always_comb begin
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (halted_d) begin
      req_d = 1'b0;
    end else begin
      case (t_d)
        T0: begin
          req_d  = 1'b1;
          addr_d = pc_d;
        end
        T2: begin
          if (is_mem_op(op_next_s)) begin
            req_d   = 1'b1;
            we_d    = (op_next_s == OP_STA);
            addr_d  = opnd_next_s;
            wdata_d = ac_d;
          end else begin
            req_d = 1'b0;
          end
        end
        default: req_d = 1'b0;
      endcase
    end
  end

  // State registers; reset abandons any outstanding access.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      t_q      <= T0;
      pc_q     <= ADDR_W'(RESET_PC);
      ac_q     <= AC_ZERO;
      ir_q     <= {DATA_W{1'b0}};
      mdr_q    <= {DATA_W{1'b0}};
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
    end else begin
      t_q      <= t_d;
      pc_q     <= pc_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign MEM_REQ   = req_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign PC_OUT    = pc_q;
  assign AC_OUT    = ac_q;
  assign IR_OUT    = op_s;
  assign T_OUT     = t_q;
  assign FETCH     = ~t_q[1];
  assign EXECUTE   = t_q[1];
  assign CARRY     = carry_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_dunc_core.sv
// Scoreboard bench for dunc_core: an instruction-level model predicts every
// memory access and the final architectural state; a monitor compares each
// accepted access against the predicted queue.
module tb_dunc_core;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          MEM_REQ, MEM_WE, MEM_ACK;
  logic [AW-1:0] MEM_ADDR, PC_OUT;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA, AC_OUT;
  logic [3:0]    IR_OUT;
  logic [1:0]    T_OUT;
  logic          FETCH, EXECUTE, CARRY, HALTED;

  always #5 CLK = ~CLK;

  dunc_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .PC_OUT(PC_OUT), .AC_OUT(AC_OUT), .IR_OUT(IR_OUT),
    .T_OUT(T_OUT), .FETCH(FETCH), .EXECUTE(EXECUTE), .CARRY(CARRY),
    .HALTED(HALTED)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] mem [0:4095];
  logic [15:0] mm  [0:4095];

  typedef struct packed {
    logic        fetch;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } txn_t;
  txn_t sb_q[$];
  txn_t mon_e;

  // Reference model: whole-instruction interpreter over a memory copy.
  logic [11:0] m_pc;
  logic [15:0] m_ac;
  logic        m_carry;
  int          m_n;

  task automatic run_model();
    m_pc = 12'h000; m_ac = 16'h0000; m_carry = 1'b0; m_n = 0;
    for (int k = 0; k < 500; k++) begin
      logic [15:0] ins;
      logic [15:0] d;
      logic [3:0]  op;
      logic [11:0] a;
      int          s;
      ins = mm[m_pc]; op = ins[15:12]; a = ins[11:0]; d = mm[a];
      m_n++;
      sb_q.push_back(txn_t'{1'b1, 1'b0, m_pc, 16'h0000});
      case (op)
        4'd1: begin sb_q.push_back(txn_t'{1'b0, 1'b0, a, 16'h0000}); m_ac = d; end
        4'd2: begin sb_q.push_back(txn_t'{1'b0, 1'b1, a, m_ac}); mm[a] = m_ac; end
        4'd3: begin
          sb_q.push_back(txn_t'{1'b0, 1'b0, a, 16'h0000});
          s = int'(m_ac) + int'(d);
          m_carry = (s > 65535);
          m_ac = 16'(s);
        end
        4'd4: begin
          sb_q.push_back(txn_t'{1'b0, 1'b0, a, 16'h0000});
          m_carry = (m_ac >= d);
          m_ac = m_ac - d;
        end
        4'd5: begin sb_q.push_back(txn_t'{1'b0, 1'b0, a, 16'h0000}); m_ac = m_ac & d; end
        default: ;
      endcase
      if (op == 4'd6 || (op == 4'd7 && m_ac == 16'h0000) || (op == 4'd8 && m_ac[15]))
        m_pc = a;
      else
        m_pc = m_pc + 12'h001;
      if (op == 4'd0) break;
    end
  endtask

  // Memory responder: drives ACK/RDATA mid-cycle with a configurable delay.
  int wait_mode = 0;   // 0 zero wait, 1 fixed, 2 random 0..3, 3 hold off
  int wait_fixed = 0;
  int cur_wait = 0;
  int waited = 0;
  int total_wait = 0;
  bit in_req = 1'b0;
  bit stray_ack = 1'b0;

  initial begin
    MEM_ACK = 1'b0;
    MEM_RDATA = 16'h0000;
    forever begin
      @(negedge CLK); #1;
      if (stray_ack) begin
        MEM_ACK = 1'b1; MEM_RDATA = 16'h5555; in_req = 1'b0;
      end else if (MEM_REQ) begin
        if (!in_req) begin
          in_req = 1'b1; waited = 0;
          case (wait_mode)
            0: cur_wait = 0;
            1: cur_wait = wait_fixed;
            2: cur_wait = int'($urandom_range(0, 3));
            default: cur_wait = 1000000;
          endcase
        end
        if (waited >= cur_wait) begin
          MEM_ACK = 1'b1;
          MEM_RDATA = MEM_WE ? 16'($urandom) : mem[MEM_ADDR];
          if (MEM_WE && !RESET) mem[MEM_ADDR] = MEM_WDATA;
          total_wait += cur_wait;
          in_req = 1'b0;
        end else begin
          MEM_ACK = 1'b0; MEM_RDATA = 16'($urandom); waited++;
        end
      end else begin
        MEM_ACK = 1'b0; MEM_RDATA = 16'($urandom); in_req = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted access and watches
  // request stability, request drop and idle bus while halted.
  bit          prev_valid = 1'b0;
  bit          prev_req, prev_ack, prev_we;
  logic [11:0] prev_addr;
  logic [15:0] prev_wdata;
  bit          ir_chk = 1'b0;
  logic [3:0]  ir_exp;

  initial begin
    forever begin
      @(negedge CLK); #2;
      check("fetch_execute", {FETCH, EXECUTE}, (T_OUT < 2'd2) ? 32'd2 : 32'd1);
      if (RESET) begin
        prev_valid = 1'b0; ir_chk = 1'b0;
      end else begin
        if (ir_chk) begin
          check("ir_opcode", IR_OUT, ir_exp);
          check("t1_after_fetch", T_OUT, 2'd1);
          ir_chk = 1'b0;
        end
        if (prev_valid && prev_req && !prev_ack) begin
          check("req_held", MEM_REQ, 1'b1);
          check("addr_stable", MEM_ADDR, prev_addr);
          check("we_stable", MEM_WE, prev_we);
          if (prev_we) check("wdata_stable", MEM_WDATA, prev_wdata);
        end
        if (prev_valid && prev_req && prev_ack) check("req_drop", MEM_REQ, 1'b0);
        if (HALTED) check("halt_no_req", MEM_REQ, 1'b0);
        if (MEM_REQ && MEM_ACK) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: access at %0h we %0b, none expected", MEM_ADDR, MEM_WE);
          end else begin
            mon_e = sb_q.pop_front();
            check("acc_addr", MEM_ADDR, mon_e.addr);
            check("acc_we", MEM_WE, mon_e.we);
            if (mon_e.we) check("acc_wdata", MEM_WDATA, mon_e.wdata);
            if (mon_e.fetch) begin ir_chk = 1'b1; ir_exp = MEM_RDATA[15:12]; end
          end
        end
        prev_valid = 1'b1; prev_req = MEM_REQ; prev_ack = MEM_ACK;
        prev_we = MEM_WE; prev_addr = MEM_ADDR; prev_wdata = MEM_WDATA;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic prep_model();
    sb_q.delete();
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    run_model();
  endtask

  // Two reset cycles, release, then one cycle for the first fetch request.
  task automatic do_reset(input bit chk);
    @(negedge CLK); RESET = 1'b1;
    repeat (2) @(negedge CLK);
    if (chk) begin
      check("rst_pc", PC_OUT, 12'h000);
      check("rst_ac", AC_OUT, 16'h0000);
      check("rst_carry", CARRY, 1'b0);
      check("rst_req", MEM_REQ, 1'b0);
      check("rst_we", MEM_WE, 1'b0);
      check("rst_halted", HALTED, 1'b0);
      check("rst_t", T_OUT, 2'd0);
      check("rst_ir", IR_OUT, 4'd0);
    end
    RESET = 1'b0; total_wait = 0;
    @(negedge CLK);
    if (chk) begin
      check("first_req", MEM_REQ, 1'b1);
      check("first_addr", MEM_ADDR, 12'h000);
    end
  endtask

  // Waits for HALTED (bounded) and compares cycles and final state.
  task automatic finish_prog(input string name, input int exp_cycles);
    int cyc;
    bit ok;
    logic [11:0] pc_hold;
    cyc = 1; ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (HALTED) begin ok = 1'b1; break; end
      cyc++;
    end
    check({name, "_halted"}, ok, 1'b1);
    check({name, "_cycles"}, cyc, (exp_cycles >= 0) ? exp_cycles : 4 * m_n + total_wait);
    check({name, "_pc"}, PC_OUT, m_pc);
    check({name, "_ac"}, AC_OUT, m_ac);
    check({name, "_carry"}, CARRY, m_carry);
    pc_hold = PC_OUT;
    repeat (4) @(negedge CLK);
    #3;
    check({name, "_hold_pc"}, PC_OUT, m_pc);
    check({name, "_hold_halted"}, HALTED, 1'b1);
    check({name, "_sb_empty"}, sb_q.size(), 0);
    if (pc_hold !== PC_OUT) check({name, "_pc_moved"}, PC_OUT, pc_hold);
  endtask

  logic [3:0] op_tab [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd15};

  // Straight-line random program with forward-only jumps, ending in HLT.
  task automatic gen_random();
    clear_mem();
    for (int a = 0; a < 30; a++) begin
      logic [3:0]  op;
      logic [11:0] t;
      op = op_tab[$urandom_range(0, 10)];
      if (op == 4'd6 || op == 4'd7 || op == 4'd8) begin
        t = 12'(a + 1 + int'($urandom_range(0, 3)));
        if (t > 12'd30) t = 12'd30;
      end else begin
        t = 12'h040 + 12'($urandom_range(0, 15));
      end
      mem[a] = {op, t};
    end
    mem[30] = 16'h0000;
    for (int a = 12'h040; a < 12'h050; a++) mem[a] = 16'($urandom);
  endtask

  initial begin
    int ok;

    // Reset values plus the zero-wait reference program.
    clear_mem();
    mem[12'h000] = 16'h1010; mem[12'h001] = 16'h3011; mem[12'h002] = 16'h2020;
    mem[12'h003] = 16'h0000; mem[12'h010] = 16'h1234; mem[12'h011] = 16'hF000;
    wait_mode = 0;
    prep_model();
    do_reset(1'b1);
    finish_prog("prog", 16);
    check("prog_mem020", mem[12'h020], 16'h0234);
    check("prog_ac_abs", AC_OUT, 16'h0234);
    check("prog_carry_abs", CARRY, 1'b1);
    check("prog_pc_abs", PC_OUT, 12'h004);

    // Three wait cycles on every access: LDA 10 cycles, HLT 7.
    clear_mem();
    mem[12'h000] = 16'h1010; mem[12'h001] = 16'h0000; mem[12'h010] = 16'h1234;
    wait_mode = 1; wait_fixed = 3;
    prep_model();
    do_reset(1'b0);
    finish_prog("waits", 17);
    check("waits_ac_abs", AC_OUT, 16'h1234);

    // Branches: JZ taken, JZ not taken, JN taken.
    clear_mem();
    mem[12'h000] = 16'h7100;
    mem[12'h100] = 16'h1180; mem[12'h101] = 16'h7100; mem[12'h102] = 16'h1181;
    mem[12'h103] = 16'h8200; mem[12'h200] = 16'h0000;
    mem[12'h180] = 16'h0001; mem[12'h181] = 16'h8000;
    wait_mode = 0;
    prep_model();
    do_reset(1'b0);
    finish_prog("branch", 24);
    check("branch_pc_abs", PC_OUT, 12'h201);

    // PC wrap through a NOP at 0xFFF.
    clear_mem();
    mem[12'h000] = 16'h8005; mem[12'h001] = 16'h1010; mem[12'h002] = 16'h6FFF;
    mem[12'h005] = 16'h0000; mem[12'h010] = 16'h8000; mem[12'hFFF] = 16'h9000;
    prep_model();
    do_reset(1'b0);
    finish_prog("wrap", 24);
    check("wrap_pc_abs", PC_OUT, 12'h006);

    // Reset in T2 of an LDA, with an acknowledge arriving afterwards.
    clear_mem();
    mem[12'h000] = 16'h1010; mem[12'h001] = 16'h0000; mem[12'h010] = 16'h4321;
    wait_mode = 0;
    sb_q.delete();
    sb_q.push_back(txn_t'{1'b1, 1'b0, 12'h000, 16'h0000});
    do_reset(1'b0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (T_OUT == 2'd1) begin ok = 1; break; end
    end
    check("mid_reach_t1", ok, 1);
    wait_mode = 3;
    repeat (3) @(negedge CLK);
    check("mid_in_t2", T_OUT, 2'd2);
    check("mid_req", MEM_REQ, 1'b1);
    check("mid_addr", MEM_ADDR, 12'h010);
    RESET = 1'b1; wait_mode = 0;
    @(negedge CLK);
    RESET = 1'b0; stray_ack = 1'b1;
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    sb_q.delete();
    run_model();
    total_wait = 0;
    @(negedge CLK);
    stray_ack = 1'b0;
    check("mid_ac_kept", AC_OUT, 16'h0000);
    check("mid_t0", T_OUT, 2'd0);
    check("mid_refetch_req", MEM_REQ, 1'b1);
    check("mid_refetch_addr", MEM_ADDR, 12'h000);
    finish_prog("mid", 8);
    check("mid_ac_abs", AC_OUT, 16'h4321);

    // Random programs with random wait states.
    for (int r = 0; r < 5; r++) begin
      gen_random();
      wait_mode = (r == 4) ? 0 : 2;
      prep_model();
      do_reset(1'b0);
      finish_prog($sformatf("rand%0d", r), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dunc_core.md
DUNC_CORE -- requirements
Module: dunc_core

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set accumulator, memory data and instruction width.
REQ-002 Parameter ADDR_W, default 12, SHALL set PC and memory address width; legal configurations SHALL satisfy DATA_W >= ADDR_W+4.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded by reset.
REQ-004 Ports SHALL be:
  CLK  in  1  sole clock; all state updates on its rising edge
  RESET  in  1  synchronous, active-high reset
  MEM_REQ  out  1  memory access request
  MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ=1
  MEM_ADDR  out  ADDR_W  access address
  MEM_WDATA  out  DATA_W  write data (AC)
  MEM_RDATA  in  DATA_W  read data; sampled when MEM_ACK=1
  MEM_ACK  in  1  access complete
  PC_OUT  out  ADDR_W  program counter
  AC_OUT  out  DATA_W  accumulator
  IR_OUT  out  4  current opcode
  T_OUT  out  2  timing state (0=T0 .. 3=T3)
  FETCH  out  1  high in T0, T1
  EXECUTE  out  1  high in T2, T3
  CARRY  out  1  carry flag
  HALTED  out  1  core stopped

Function
REQ-005 Instruction format: opcode = bits [DATA_W-1:DATA_W-4]; operand address = bits [ADDR_W-1:0]; remaining bits ignored.
REQ-006 Opcodes: 0 HLT, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 JMP, 7 JZ (AC==0), 8 JN (AC MSB=1); 9-15 SHALL execute as NOP.
REQ-007 Each instruction SHALL pass T0->T1->T2->T3->T0; with zero-wait memory every instruction takes exactly 4 cycles.
REQ-008 T0: MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC; on MEM_ACK, IR <= MEM_RDATA and advance to T1; else stay in T0.
REQ-009 T1 (decode): one cycle, no memory access.
REQ-010 T2: LDA/ADD/SUB/AND SHALL read the operand address; STA SHALL write AC to the operand address; state advances only on MEM_ACK; all other opcodes spend exactly one cycle in T2.
REQ-011 T3: LDA AC<=data; ADD {CARRY,AC}<=AC+data; SUB AC<=AC-data, CARRY<=1 iff AC>=data unsigned; AND AC<=AC&data; other opcodes leave AC and CARRY unchanged.
REQ-012 T3 PC update: JMP, taken JZ and taken JN SHALL load the operand address; otherwise PC<=PC+1 modulo 2^ADDR_W (0x...FFF wraps to 0).
REQ-013 JZ/JN conditions SHALL be evaluated on the AC value present in T3.
REQ-014 HLT in T3 SHALL set PC<=PC+1, assert HALTED and stop; while halted MEM_REQ=0, all registers hold, and only RESET exits.
REQ-015 Handshake: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA SHALL stay stable from request assertion until the edge at which MEM_ACK=1 is sampled; MEM_REQ SHALL be 0 in the following cycle (T1 or T3).
REQ-016 ACK in the same cycle as REQ assertion (zero wait) SHALL be accepted; MEM_ACK while MEM_REQ=0 SHALL be ignored.
REQ-017 Wait cycles SHALL be unbounded; no timeout.

Reset
REQ-018 RESET=1 at a rising edge SHALL set PC=RESET_PC, AC=0, IR=0, CARRY=0, HALTED=0, T_OUT=0, MEM_REQ=0, MEM_WE=0, overriding any state including HALTED and outstanding accesses.
REQ-019 RESET SHALL hold MEM_REQ=0 while asserted; the first fetch request at RESET_PC SHALL appear in the first cycle after RESET deasserts.
REQ-020 MEM_ACK for an access abandoned by reset SHALL NOT update any register.

Verification
REQ-021 Reset: RESET high 2 cycles, RESET_PC=0 -> PC=000, AC=0000, CARRY=0, MEM_REQ=0; next cycle MEM_REQ=1, MEM_ADDR=000.
REQ-022 Program, zero wait: mem[000]=0x1010, [001]=0x3011, [002]=0x2020, [003]=0x0000, [010]=0x1234, [011]=0xF000 -> write 0x0234 to 0x020, AC=0x0234, CARRY=1, HALTED=1 after 16 cycles, PC=0x004.
REQ-023 Wait states: every MEM_ACK delayed 3 cycles on the LDA -> LDA takes 10 cycles; MEM_ADDR stable over each request; AC=0x1234 afterwards.
REQ-024 Branches: AC=0, JZ 0x100 -> next fetch 0x100; AC=0x0001, JZ 0x100 -> PC+1; AC=0x8000, JN 0x200 -> next fetch 0x200.
REQ-025 Wrap: PC=0xFFF holding opcode 9 (NOP) -> next fetch at 0x000.
REQ-026 Reset mid-access: RESET in T2 of an LDA with MEM_REQ=1, MEM_ACK arriving afterwards -> AC stays 0000; next fetch at 000.
